rv_ex_stage_mdu: RTL

RV_EX_STAGE_MDU -- requirements
Module: rv_ex_stage_mdu

---
 rtl/rv_ex_stage_mdu.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_ex_stage_mdu.sv
// rv_ex_stage_mdu -- RV32IM execute stage with an iterative multiply/divide unit.
//
// Purpose: resolves operand forwarding, the integer ALU, branch/jump redirects,
// and RV32M operations, then registers everything into the EX/MEM pipeline
// register. M-extension operations stall the front end while they run.
//
// Ports:
//   i_ex_clk, i_ex_rstn          clock (rising edge), async active-low reset
//   i_ex_pc, i_ex_immext_res     instruction PC and extended immediate
//   i_ex_rf_rd1/2, *_rd_mem/_wb  register data and forwarded MEM/WB results
//   i_ex_rf_rd1/2_sel            forward select: 01 MEM, 10 WB, else RF
//   i_ex_alu_ctrl                0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL,
//                                6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 pass B
//   i_ex_alu_b_sel               1: operand B = rd2, 0: operand B = immediate
//   i_ex_func3                   branch condition, or M operation when is_mdu
//   i_ex_is_br_jp                01 branch, 10 jalr, 11 jal
//   i_ex_is_mdu                  instruction is RV32M
//   i_ex_is_load ... wd_pre_sel  control fields carried into EX/MEM
//   o_ex_stall                   freeze PC, IF/ID and ID/EX
//   o_ex_flush_ifid              squash IF/ID on a redirect
//   o_ex_if_pc_next_sel          00 pc+4, 01 pc+imm, 10 alu_res & ~1
//   o_ex_if_pc_plus_imm/alu_res  redirect targets
//   o_ex_mem_*                   EX/MEM pipeline register outputs
module rv_ex_stage_mdu #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            i_ex_clk,
  input  logic            i_ex_rstn,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_immext_res,
  input  logic [XLEN-1:0] i_ex_rf_rd1,
  input  logic [XLEN-1:0] i_ex_rf_rd2,
  input  logic [XLEN-1:0] i_ex_rf_rd_mem,
  input  logic [XLEN-1:0] i_ex_rf_rd_wb,
  input  logic [1:0]      i_ex_rf_rd1_sel,
  input  logic [1:0]      i_ex_rf_rd2_sel,
  input  logic [3:0]      i_ex_alu_ctrl,
  input  logic            i_ex_alu_b_sel,
  input  logic [2:0]      i_ex_func3,
  input  logic [1:0]      i_ex_is_br_jp,
  input  logic            i_ex_is_mdu,
  input  logic            i_ex_is_load,
  input  logic            i_ex_dmem_we,
  input  logic [2:0]      i_ex_dmem_bytectrl,
  input  logic [4:0]      i_ex_rf_wa,
  input  logic            i_ex_rf_we,
  input  logic [1:0]      i_ex_rf_wd_pre_sel,
  output logic            o_ex_stall,
  output logic            o_ex_flush_ifid,
  output logic [1:0]      o_ex_if_pc_next_sel,
  output logic [XLEN-1:0] o_ex_if_pc_plus_imm,
  output logic [XLEN-1:0] o_ex_if_alu_res,
  output logic            o_ex_mem_is_load,
  output logic            o_ex_mem_dmem_we,
  output logic [2:0]      o_ex_mem_dmem_bytectrl,
  output logic [4:0]      o_ex_mem_rf_wa,
  output logic            o_ex_mem_rf_we,
  output logic [1:0]      o_ex_mem_rf_wd_pre_sel,
  output logic [XLEN-1:0] o_ex_mem_alu_res,
  output logic [XLEN-1:0] o_ex_mem_immext_res,
  output logic [XLEN-1:0] o_ex_mem_pc_plus_imm,
  output logic [XLEN-1:0] o_ex_mem_pc_plus_4,
  output logic [XLEN-1:0] o_ex_mem_dmem_wd
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] DIV_LOAD = CW'(XLEN - 2);
  localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res, a_mag, b_mag;
  logic [XLEN-1:0] op_a, op_b, lat_pc, lat_imm, div_rem, div_quo, div_dvs;
  logic [XLEN-1:0] quo_fix, rem_fix, mdu_res;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic [2:0] lat_f3, lat_bytectrl;
  logic [4:0] lat_wa;
  logic [1:0] lat_wd_sel;
  logic lat_is_load, lat_dmem_we, lat_rf_we, lat_div0, lat_ovf;
  logic issue, iss_signed, lat_signed, taken;
  logic [1:0] pc_next_sel;

  function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel,
                                          input logic [XLEN-1:0] rf, mem, wb);
    case (sel)
      2'b01:   fwd = mem;
      2'b10:   fwd = wb;
      default: fwd = rf;
    endcase
  endfunction

  // One restoring-division step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. Returns {rem, quo}.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem, quo, dvs);
    logic [XLEN:0] sh, diff;
    sh   = {rem, quo[XLEN-1]};
    diff = sh - {1'b0, dvs};
    if (!diff[XLEN]) div_step = {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
    else             div_step = {sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
  endfunction

  assign fwd_a = fwd(i_ex_rf_rd1_sel, i_ex_rf_rd1, i_ex_rf_rd_mem, i_ex_rf_rd_wb);
  assign fwd_b = fwd(i_ex_rf_rd2_sel, i_ex_rf_rd2, i_ex_rf_rd_mem, i_ex_rf_rd_wb);
  assign alu_b = i_ex_alu_b_sel ? fwd_b : i_ex_immext_res;

  assign issue      = (state == IDLE) && i_ex_is_mdu;
  assign iss_signed = ~i_ex_func3[0];
  assign a_mag = (iss_signed && fwd_a[XLEN-1]) ? -fwd_a : fwd_a;
  assign b_mag = (iss_signed && fwd_b[XLEN-1]) ? -fwd_b : fwd_b;

  always_comb begin
    alu_res = '0;
    case (i_ex_alu_ctrl)
      4'd0:  alu_res = fwd_a + alu_b;
      4'd1:  alu_res = fwd_a - alu_b;
      4'd2:  alu_res = fwd_a & alu_b;
      4'd3:  alu_res = fwd_a | alu_b;
      4'd4:  alu_res = fwd_a ^ alu_b;
      4'd5:  alu_res = fwd_a << alu_b[CW-1:0];
      4'd6:  alu_res = fwd_a >> alu_b[CW-1:0];
      4'd7:  alu_res = $signed(fwd_a) >>> alu_b[CW-1:0];
      4'd8:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
      4'd9:  alu_res = {{(XLEN-1){1'b0}}, fwd_a < alu_b};
      4'd10: alu_res = alu_b;
      default: alu_res = '0;
    endcase
  end

  // Branch compare always uses rd2, independent of the ALU B-operand select.
  always_comb begin
    taken = 1'b0;
    case (i_ex_func3)
      3'b000: taken = (fwd_a == fwd_b);
      3'b001: taken = (fwd_a != fwd_b);
      3'b100: taken = ($signed(fwd_a) < $signed(fwd_b));
      3'b101: taken = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110: taken = (fwd_a < fwd_b);
      3'b111: taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  // A stalled or M-extension instruction must never redirect fetch, even when
  // its is_br_jp field happens to be nonzero.
  always_comb begin
    pc_next_sel = 2'b00;
    if (!o_ex_stall && !i_ex_is_mdu) begin
      case (i_ex_is_br_jp)
        2'b01:   pc_next_sel = taken ? 2'b01 : 2'b00;
        2'b10:   pc_next_sel = 2'b10;
        2'b11:   pc_next_sel = 2'b01;
        default: pc_next_sel = 2'b00;
      endcase
    end
  end

  assign o_ex_if_pc_next_sel = pc_next_sel;
  assign o_ex_flush_ifid     = (pc_next_sel != 2'b00);
  assign o_ex_if_pc_plus_imm = i_ex_pc + i_ex_immext_res;
  assign o_ex_if_alu_res     = {alu_res[XLEN-1:1], 1'b0};

  // MDU state register.
  always_ff @(posedge i_ex_clk or negedge i_ex_rstn) begin
    if (!i_ex_rstn) state <= IDLE;
    else            state <= state_next;
  end

  // The issue cycle counts as the first multiply stage / divide step, so the
  // busy states last one cycle less than the total stall. Special divide
  // cases are fully decided at issue and skip straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_ex_is_mdu) begin
        if (i_ex_func3[2])
          state_next = (fwd_b == '0 || (iss_signed && fwd_a == MOST_NEG && fwd_b == '1))
                       ? DONE : DIV;
        else
          state_next = (MUL_STAGES == 1) ? DONE : MUL;
      end
      MUL:  if (cnt == '0) state_next = DONE;
      DIV:  if (cnt == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall is gated by reset so it drops without waiting for a clock edge.
  always_comb begin
    o_ex_stall = i_ex_rstn && (issue || state == MUL || state == DIV);
    lat_signed = ~lat_f3[0];
    mul_a = (lat_f3[1:0] == 2'b01 || lat_f3[1:0] == 2'b10)
            ? {{XLEN{op_a[XLEN-1]}}, op_a} : {{XLEN{1'b0}}, op_a};
    mul_b = (lat_f3[1:0] == 2'b01) ? {{XLEN{op_b[XLEN-1]}}, op_b} : {{XLEN{1'b0}}, op_b};
    product = mul_a * mul_b;
    quo_fix = (lat_signed && (op_a[XLEN-1] ^ op_b[XLEN-1])) ? -div_quo : div_quo;
    rem_fix = (lat_signed && op_a[XLEN-1]) ? -div_rem : div_rem;
    if (lat_div0) begin
      quo_fix = '1;
      rem_fix = op_a;
    end else if (lat_ovf) begin
      quo_fix = op_a;
      rem_fix = '0;
    end
    if (!lat_f3[2])
      mdu_res = (lat_f3[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    else
      mdu_res = lat_f3[1] ? rem_fix : quo_fix;
  end

  // Operand/field latches and the iterative divider datapath.
  always_ff @(posedge i_ex_clk or negedge i_ex_rstn) begin
    if (!i_ex_rstn) begin
      cnt <= '0; op_a <= '0; op_b <= '0; lat_pc <= '0; lat_imm <= '0;
      div_rem <= '0; div_quo <= '0; div_dvs <= '0; lat_f3 <= '0;
      lat_bytectrl <= '0; lat_wa <= '0; lat_wd_sel <= '0; lat_is_load <= 1'b0;
      lat_dmem_we <= 1'b0; lat_rf_we <= 1'b0; lat_div0 <= 1'b0; lat_ovf <= 1'b0;
    end else if (issue) begin
      cnt          <= i_ex_func3[2] ? DIV_LOAD : MUL_LOAD;
      op_a         <= fwd_a;
      op_b         <= fwd_b;
      lat_pc       <= i_ex_pc;
      lat_imm      <= i_ex_immext_res;
      lat_f3       <= i_ex_func3;
      lat_bytectrl <= i_ex_dmem_bytectrl;
      lat_wa       <= i_ex_rf_wa;
      lat_wd_sel   <= i_ex_rf_wd_pre_sel;
      lat_is_load  <= i_ex_is_load;
      lat_dmem_we  <= i_ex_dmem_we;
      lat_rf_we    <= i_ex_rf_we;
      lat_div0     <= (fwd_b == '0);
      lat_ovf      <= iss_signed && fwd_a == MOST_NEG && fwd_b == '1;
      div_dvs      <= b_mag;
      {div_rem, div_quo} <= div_step('0, a_mag, b_mag);
    end else if (state == MUL || state == DIV) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      if (state == DIV) {div_rem, div_quo} <= div_step(div_rem, div_quo, div_dvs);
    end
  end

  // EX/MEM register: MDU results in DONE, bubbles while stalled, else normal.
  always_ff @(posedge i_ex_clk or negedge i_ex_rstn) begin
    if (!i_ex_rstn) begin
      o_ex_mem_is_load <= 1'b0; o_ex_mem_dmem_we <= 1'b0; o_ex_mem_dmem_bytectrl <= '0;
      o_ex_mem_rf_wa <= '0; o_ex_mem_rf_we <= 1'b0; o_ex_mem_rf_wd_pre_sel <= '0;
      o_ex_mem_alu_res <= '0; o_ex_mem_immext_res <= '0; o_ex_mem_pc_plus_imm <= '0;
      o_ex_mem_pc_plus_4 <= '0; o_ex_mem_dmem_wd <= '0;
    end else if (state == DONE) begin
      o_ex_mem_is_load       <= lat_is_load;
      o_ex_mem_dmem_we       <= lat_dmem_we;
      o_ex_mem_dmem_bytectrl <= lat_bytectrl;
      o_ex_mem_rf_wa         <= lat_wa;
      o_ex_mem_rf_we         <= lat_rf_we;
      o_ex_mem_rf_wd_pre_sel <= lat_wd_sel;
      o_ex_mem_alu_res       <= mdu_res;
      o_ex_mem_immext_res    <= lat_imm;
      o_ex_mem_pc_plus_imm   <= lat_pc + lat_imm;
      o_ex_mem_pc_plus_4     <= lat_pc + XLEN'(4);
      o_ex_mem_dmem_wd       <= op_b;
    end else begin
      o_ex_mem_is_load       <= i_ex_is_load && !o_ex_stall;
      o_ex_mem_dmem_we       <= i_ex_dmem_we && !o_ex_stall;
      o_ex_mem_dmem_bytectrl <= i_ex_dmem_bytectrl;
      o_ex_mem_rf_wa         <= i_ex_rf_wa;
      o_ex_mem_rf_we         <= i_ex_rf_we && !o_ex_stall;
      o_ex_mem_rf_wd_pre_sel <= i_ex_rf_wd_pre_sel;
      o_ex_mem_alu_res       <= alu_res;
      o_ex_mem_immext_res    <= i_ex_immext_res;
      o_ex_mem_pc_plus_imm   <= i_ex_pc + i_ex_immext_res;
      o_ex_mem_pc_plus_4     <= i_ex_pc + XLEN'(4);
      o_ex_mem_dmem_wd       <= fwd_b;
    end
  end

endmodule
